// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and bit-timing helper for the transmit and receive paths
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_t;

    function automatic int clks_per_bit(input int input_clock, input int baud_rate);
        return input_clock / baud_rate;
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - single-clock show-ahead byte FIFO, extra pointer bit separates full from empty
module tx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_push,
    input  logic                          i_pop,
    input  logic [7:0]                    i_din,
    output logic [7:0]                    o_dout,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [7:0]  r_mem [FIFO_DEPTH];
    logic        w_push;
    logic        w_pop;

    // A full FIFO refuses a push even when a pop lands on the same edge.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-buffered UART transmitter, 8N1 LSB first; UART_TX_PARITY_EN inserts an even-parity bit (8E1)
module uart_tx
    import uart_pkg::*;
#(
    parameter int INPUT_CLOCK = 27000000,
    parameter int BAUD_RATE   = 9600,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_TX_Data,
    input  logic                          i_TX_DataValid,
    output logic                          o_TX_Ready,
    output logic                          o_TX,
    output logic                          o_TX_Busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifoCount
);

    localparam int CLKS_PER_BIT = clks_per_bit(INPUT_CLOCK, BAUD_RATE);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    uart_state_t r_state;
    uart_state_t w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_next;
    logic [7:0]    r_byte;
    logic [7:0]    w_byte_next;
    logic          w_tx_next;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_cnt_last;
    logic [7:0]    w_fifo_dout;

    tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_TX_DataValid),
        .i_pop   (w_pop),
        .i_din   (i_TX_Data),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_fifoCount)
    );

    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign o_TX_Ready = ~w_full;
    assign o_TX_Busy  = (r_state != S_IDLE) | ~w_empty;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + CNT_ONE;
        w_bit_next   = r_bit;
        w_byte_next  = r_byte;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_byte_next  = w_fifo_dout;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_cnt_last) begin
                    w_cnt_next   = '0;
                    w_bit_next   = '0;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_next = r_byte[r_bit];
                if (w_cnt_last) begin
                    w_cnt_next = '0;
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_tx_next = ^r_byte;
                if (w_cnt_last) begin
                    w_cnt_next   = '0;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Popping here chains the next start bit straight onto this stop bit.
                if (w_cnt_last) begin
                    w_cnt_next = '0;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_byte_next  = w_fifo_dout;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            o_TX    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_byte  <= w_byte_next;
            o_TX    <= w_tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with a line decoder and byte scoreboard
module tb_uart_tx;

    localparam int INPUT_CLOCK = 16;
    localparam int BAUD_RATE   = 1;
    localparam int FIFO_DEPTH  = 4;
    localparam int CPB         = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_line;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    bit         rx_ok_q[$];
    int         rx_start_q[$];

    uart_tx #(
        .INPUT_CLOCK (INPUT_CLOCK),
        .BAUD_RATE   (BAUD_RATE),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_TX_Data      (tx_data),
        .i_TX_DataValid (tx_valid),
        .o_TX_Ready     (tx_ready),
        .o_TX           (tx_line),
        .o_TX_Busy      (tx_busy),
        .o_fifoCount    (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference line level for bit slot k of a frame carrying byte b.
    function automatic logic bit_at(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (NB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Occupancy t edges after the first of six held bytes lands in an empty FIFO.
    function automatic int exp_occ(input int t);
        if (t <= 1) return 1;
        if (t < 4) return t;
        if (t == FRAME + 1) return 3;
        return 4;
    endfunction

    // Line decoder: samples mid-bit, drops frames cut by reset.
    initial begin
        logic [NB-1:0] bits;
        int st;
        bit ab;
        forever begin
            @(negedge clk);
            if (!rst && tx_line === 1'b0) begin
                st = cyc;
                ab = 1'b0;
                bits = '0;
                for (int c = 1; c < FRAME; c++) begin
                    @(negedge clk);
                    if (rst) begin
                        ab = 1'b1;
                        break;
                    end
                    if (c % CPB == CPB / 2) bits[c / CPB] = tx_line;
                end
                if (!ab) begin
                    rx_q.push_back(bits[8:1]);
                    rx_ok_q.push_back(bits[0] == 1'b0 && bits[NB-1] == 1'b1);
                    rx_start_q.push_back(st);
                end
            end
        end
    end

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 4 * FRAME && tx_busy !== 1'b0; i++) @(negedge clk);
        chk("idle_wait", tx_busy, 0);
    endtask

    task automatic check_rx(input string tag);
        for (int i = 0; i < 8 * FRAME && rx_q.size() < exp_q.size(); i++) @(negedge clk);
        chk({tag, "_frame_count"}, rx_q.size(), exp_q.size());
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            chk({tag, "_byte"}, rx_q.pop_front(), exp_q.pop_front());
            chk({tag, "_framing"}, rx_ok_q.pop_front(), 1);
        end
        rx_q.delete();
        rx_ok_q.delete();
        exp_q.delete();
    endtask

    task automatic send_and_trace(input logic [7:0] b);
        int bad;
        wait_idle();
        tx_data = b;
        tx_valid = 1'b1;
        chk("ready_before_push", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        exp_q.push_back(b);
        chk("line_after_accept", tx_line, 1);
        chk("count_after_accept", fifo_count, 1);
        @(negedge clk);
        chk("line_after_pop", tx_line, 1);
        chk("count_after_pop", fifo_count, 0);
        bad = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (tx_line !== bit_at(b, k / CPB)) bad++;
            if (k == FRAME - 2) chk("busy_last_frame_cycle", tx_busy, 1);
        end
        chk("frame_trace_bad_cycles", bad, 0);
        chk("busy_after_frame", tx_busy, 0);
        @(negedge clk);
        chk("line_idle_after_frame", tx_line, 1);
    endtask

    initial begin
        logic [7:0] b3 [6];
        logic [7:0] b0, b2, x0, x1, x2, x3;
        int idx, n0, e, t;
        logic rdy;

        #2 rst = 1'b1;
        #1;
        chk("rst_line", tx_line, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_count", fifo_count, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: single frame, exact line trace
        send_and_trace(8'hA5);
        check_rx("t1");

        // 2: three back-to-back frames
        wait_idle();
        rx_start_q.delete();
        tx_valid = 1'b1;
        tx_data = 8'h55;
        @(negedge clk);
        chk("t2_count_1", fifo_count, 1);
        tx_data = 8'h0F;
        @(negedge clk);
        chk("t2_count_2", fifo_count, 1);
        tx_data = 8'hF0;
        @(negedge clk);
        chk("t2_count_3", fifo_count, 2);
        tx_valid = 1'b0;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'hF0);
        check_rx("t2");
        chk("t2_starts", rx_start_q.size(), 3);
        if (rx_start_q.size() >= 3) begin
            chk("t2_gap_1", rx_start_q[1] - rx_start_q[0], FRAME);
            chk("t2_gap_2", rx_start_q[2] - rx_start_q[1], FRAME);
        end
        wait_idle();
        chk("t2_drained", fifo_count, 0);

        // 3: hold valid across a full FIFO
        for (int i = 0; i < 6; i++) b3[i] = 8'($urandom);
        wait_idle();
        idx = 0;
        n0 = -1;
        e = 0;
        for (int c = 0; c < FRAME + 45; c++) begin
            if (n0 >= 0) begin
                t = e - n0;
                chk("t3_count", fifo_count, exp_occ(t));
                chk("t3_ready", tx_ready, exp_occ(t) != 4);
            end
            if (idx < 6) begin
                tx_valid = 1'b1;
                tx_data = b3[idx];
            end else begin
                tx_valid = 1'b0;
            end
            rdy = tx_ready;
            @(posedge clk);
            e++;
            if (idx < 6 && rdy) begin
                exp_q.push_back(b3[idx]);
                if (idx == 0) n0 = e;
                idx++;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
        chk("t3_all_accepted", idx, 6);
        check_rx("t3");

        // 4: reset in the middle of the second queued frame
        b0 = 8'($urandom);
        b2 = 8'($urandom);
        wait_idle();
        tx_valid = 1'b1;
        tx_data = b0;
        @(negedge clk);
        tx_data = 8'h00;
        @(negedge clk);
        tx_data = b2;
        @(negedge clk);
        tx_valid = 1'b0;
        exp_q.push_back(b0);
        repeat (FRAME + 58) @(negedge clk);
        chk("t4_line_mid_data", tx_line, 0);
        chk("t4_count_pre_reset", fifo_count, 1);
        #2 rst = 1'b1;
        #1;
        chk("t4_rst_line", tx_line, 1);
        chk("t4_rst_count", fifo_count, 0);
        chk("t4_rst_busy", tx_busy, 0);
        chk("t4_rst_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t4_line_after_release", tx_line, 1);
        send_and_trace(8'h3C);
        check_rx("t4");

        // 5: push and pop on the same edge with two queued
        x0 = 8'($urandom);
        x1 = 8'($urandom);
        x2 = 8'($urandom);
        x3 = 8'($urandom);
        wait_idle();
        tx_valid = 1'b1;
        tx_data = x0;
        @(negedge clk);
        chk("t5_count_1", fifo_count, 1);
        tx_data = x1;
        @(negedge clk);
        chk("t5_count_2", fifo_count, 1);
        tx_data = x2;
        @(negedge clk);
        chk("t5_count_3", fifo_count, 2);
        tx_valid = 1'b0;
        repeat (FRAME - 2) @(negedge clk);
        chk("t5_count_before", fifo_count, 2);
        tx_valid = 1'b1;
        tx_data = x3;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("t5_count_pushpop", fifo_count, 2);
        exp_q.push_back(x0);
        exp_q.push_back(x1);
        exp_q.push_back(x2);
        exp_q.push_back(x3);
        check_rx("t5");

        // 6: parity-sensitive bytes, trace covers frame length
        send_and_trace(8'h07);
        send_and_trace(8'h03);
        check_rx("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
